msrv2_wr_en_pipe_ctrl: RTL

- Parametrised, registered successor to the write-enable generator. Gates NUM_CH write-enable requests (int RF, CSR, extra channels) against flush, a multi-cycle kill shadow, pipeline stall and x0 writes.
- Presents one registered, single-pulse write enable per accepted instruction to the register files.
- Sits between the WB-stage decode registers and the integer/CSR register files.

---
 rtl/msrv2_wr_en_pipe_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/msrv2_wr_en_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : msrv2_wr_en_pipe_ctrl
//  Brief    : Registered WB-stage write-enable controller. Gates NUM_CH
//             write requests (ch0 = integer RF, ch1 = CSR, rest generic)
//             against flush, a KILL_CYCLES-long kill shadow, stall and x0
//             writes. Each accepted entry gives exactly one enable pulse.
//  Options  : MSRV2_WR_EN_DROP_CNT_EN - builds a 16-bit saturating counter
//             of edges on which requests were discarded by flush or KILL.
//             When undefined, drop_cnt_out is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module msrv2_wr_en_pipe_ctrl #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 12,
  parameter int KILL_CYCLES = 2
) (
  input  logic                       ms_riscv32_mp_clk_in,
  input  logic                       ms_riscv32_mp_rst_n_in,
  input  logic                       flush_in,
  input  logic                       stall_in,
  input  logic [NUM_CH-1:0]          wr_en_req_in,
  input  logic [NUM_CH*ADDR_W-1:0]   wr_addr_in,
  output logic [NUM_CH-1:0]          wr_en_out,
  output logic [NUM_CH*ADDR_W-1:0]   wr_addr_out,
  output logic                       kill_active_out,
  output logic [15:0]                drop_cnt_out
);

  // Kill counter reload value; KILL_CYCLES is limited to 1..15 so 4 bits suffice.
  localparam logic [3:0] KILL_LOAD = 4'(KILL_CYCLES);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    KILL = 1'b1
  } state_t;

  state_t                      state;
  state_t                      state_next;
  logic [3:0]                  kill_cnt;
  logic [3:0]                  kill_cnt_next;

  logic [NUM_CH-1:0]           stage_valid;
  logic [NUM_CH*ADDR_W-1:0]    stage_addr;
  logic                        fired;

  logic [NUM_CH-1:0]           accept_mask;
  logic                        load_stage;

  // A new entry enters the stage only on a clean, unstalled edge in RUN.
  assign load_stage = ~flush_in & ~stall_in & (state == RUN);

  // Channel 0 targets the integer RF, whose x0 must never be written.
  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      if (i == 0) begin : g_int_rf
        assign accept_mask[i] = wr_en_req_in[i] & (wr_addr_in[4:0] != 5'd0);
      end else begin : g_generic
        assign accept_mask[i] = wr_en_req_in[i];
      end
    end
  endgenerate

  // FSM state and kill counter register.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      state    <= RUN;
      kill_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      kill_cnt <= kill_cnt_next;
    end
  end

  // Next-state: flush (re)arms the shadow; it counts down only on unstalled, unflushed edges.
  always_comb begin
    state_next    = state;
    kill_cnt_next = kill_cnt;
    if (flush_in) begin
      state_next    = KILL;
      kill_cnt_next = KILL_LOAD;
    end else if ((state == KILL) && !stall_in) begin
      kill_cnt_next = kill_cnt - 4'd1;
      if (kill_cnt == 4'd1) begin
        state_next = RUN;
      end
    end
  end

  // Stage register: flush clears, stall holds (remembering a shown pulse), KILL drops, RUN loads.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      stage_valid <= '0;
      stage_addr  <= '0;
      fired       <= 1'b0;
    end else if (flush_in) begin
      stage_valid <= '0;
      fired       <= 1'b0;
    end else if (stall_in) begin
      if (|stage_valid) begin
        fired <= 1'b1;
      end
    end else if (load_stage) begin
      stage_valid <= accept_mask;
      stage_addr  <= wr_addr_in;
      fired       <= 1'b0;
    end else begin
      stage_valid <= '0;
      fired       <= 1'b0;
    end
  end

  // The fired flag masks the enable so a stalled entry pulses only once.
  assign wr_en_out       = stage_valid & {NUM_CH{~fired}};
  assign wr_addr_out     = stage_addr;
  assign kill_active_out = (state == KILL);

`ifdef MSRV2_WR_EN_DROP_CNT_EN
  logic        discard;
  logic [15:0] drop_cnt;

  // A request is discarded if flush is asserted or the kill shadow consumes this edge.
  assign discard = (|wr_en_req_in) & (flush_in | ((state == KILL) & ~stall_in));

  // Saturating drop counter, cleared only by reset.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      drop_cnt <= 16'h0000;
    end else if (discard && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign drop_cnt_out = drop_cnt;
`else
  assign drop_cnt_out = 16'h0000;
`endif

endmodule
`default_nettype wire
